// File: rtl/mips_decode_pkg.sv
// mips_decode_pkg: opcode/funct codes, hazard FSM states and forward-select encoding for the MIPS decode stage
package mips_decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  typedef enum logic {RUN, STALL} state_e;
  typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_e;
  function automatic logic fwd_hit(input logic we, input int rd, input int src);
    return we && rd != 0 && rd == src;
  endfunction
endpackage

// File: rtl/decode_register_file.sv
// decode_register_file: N_REGS x NB_DATA register file, two read ports, r0 hard-wired to 0, write-through bypass
module decode_register_file #(
  parameter int N_REGS = 32,
  parameter int NB_DATA = 32,
  localparam int NB_REG = $clog2(N_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_REG-1:0]  wa,
  input  logic [NB_DATA-1:0] wd,
  input  logic [NB_REG-1:0]  ra_a,
  input  logic [NB_REG-1:0]  ra_b,
  output logic [NB_DATA-1:0] rd_a,
  output logic [NB_DATA-1:0] rd_b
);
  logic [NB_DATA-1:0] regs [N_REGS];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we && wa != '0 && int'(wa) < N_REGS) regs[wa] <= wd;
  assign rd_a = (ra_a == '0) ? '0 : (we && wa == ra_a) ? wd : regs[ra_a];
  assign rd_b = (ra_b == '0) ? '0 : (we && wa == ra_b) ? wd : regs[ra_b];
endmodule

// File: rtl/decode_pipeline_stage.sv
// decode_pipeline_stage: MIPS ID stage with forwarding, load-use stall FSM, flush and registered ID/EX outputs
// DECODE_BRANCH_CMP_EN: resolve BEQ/BNE in decode; otherwise branch outputs tie to 0
module decode_pipeline_stage
  import mips_decode_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_REGS = 32,
  parameter int LOAD_LAT = 1,
  localparam int NB_REG = $clog2(N_REGS)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_instruction,
  input  logic [NB_DATA-1:0] i_next_pc,
  input  logic               i_flush,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_rd,
  input  logic               i_exmem_reg_write,
  input  logic [NB_REG-1:0]  i_exmem_rd,
  input  logic [NB_DATA-1:0] i_exmem_data,
  input  logic               i_memwb_reg_write,
  input  logic [NB_REG-1:0]  i_memwb_rd,
  input  logic [NB_DATA-1:0] i_memwb_data,
  output logic               o_stall,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data_ra,
  output logic [NB_DATA-1:0] o_data_rb,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [NB_DATA-1:0] o_cond_a,
  output logic [NB_DATA-1:0] o_cond_b,
  output logic               o_branch_taken,
  output logic [NB_DATA-1:0] o_branch_target
);
  logic [5:0] opcode, funct;
  logic [4:0] rs_f, rt_f, rd_f;
  logic [15:0] imm16;
  logic [NB_DATA-1:0] imm_sext, imm_zext, imm_lui, imm, rf_a_raw, rf_b_raw, rf_a, rf_b;
  fwd_e sel_a, sel_b;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic load_use, capture;
  assign opcode = i_instruction[31:26];
  assign rs_f = i_instruction[25:21];
  assign rt_f = i_instruction[20:16];
  assign rd_f = i_instruction[15:11];
  assign funct = i_instruction[5:0];
  assign imm16 = i_instruction[15:0];
  assign imm_sext = {{(NB_DATA-16){imm16[15]}}, imm16};
  assign imm_zext = NB_DATA'(imm16);
  assign imm_lui = NB_DATA'({imm16, 16'h0000});
  assign imm = (opcode inside {OP_ANDI, OP_ORI, OP_XORI}) ? imm_zext : (opcode == OP_LUI) ? imm_lui : imm_sext;
  decode_register_file #(.N_REGS(N_REGS), .NB_DATA(NB_DATA)) u_rf (
    .clk(i_clock), .rst(i_reset), .we(i_memwb_reg_write), .wa(i_memwb_rd), .wd(i_memwb_data),
    .ra_a(NB_REG'(rs_f)), .ra_b(NB_REG'(rt_f)), .rd_a(rf_a_raw), .rd_b(rf_b_raw)
  );
  // register fields that name nothing in a small register file read as zero
  assign rf_a = (int'(rs_f) < N_REGS) ? rf_a_raw : '0;
  assign rf_b = (int'(rt_f) < N_REGS) ? rf_b_raw : '0;
  assign sel_a = fwd_hit(i_exmem_reg_write, int'(i_exmem_rd), int'(rs_f)) ? FWD_EXMEM :
                 fwd_hit(i_memwb_reg_write, int'(i_memwb_rd), int'(rs_f)) ? FWD_MEMWB : FWD_RF;
  assign sel_b = fwd_hit(i_exmem_reg_write, int'(i_exmem_rd), int'(rt_f)) ? FWD_EXMEM :
                 fwd_hit(i_memwb_reg_write, int'(i_memwb_rd), int'(rt_f)) ? FWD_MEMWB : FWD_RF;
  assign o_cond_a = (sel_a == FWD_EXMEM) ? i_exmem_data : (sel_a == FWD_MEMWB) ? i_memwb_data : rf_a;
  assign o_cond_b = (sel_b == FWD_EXMEM) ? i_exmem_data : (sel_b == FWD_MEMWB) ? i_memwb_data : rf_b;
  assign load_use = i_valid && i_ex_mem_read && i_ex_rd != '0 &&
                    (int'(i_ex_rd) == int'(rs_f) || int'(i_ex_rd) == int'(rt_f));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    o_stall = 1'b0;
    capture = 1'b0;
    if (i_flush) begin
      state_d = RUN;
      cnt_d = '0;
    end else if (state_q == STALL) begin
      o_stall = 1'b1;
      cnt_d = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd1) ? RUN : STALL;
    end else if (load_use) begin
      o_stall = 1'b1;
      cnt_d = 3'(LOAD_LAT - 1);
      state_d = (LOAD_LAT > 1) ? STALL : RUN;
    end else begin
      capture = i_valid;
    end
  end
  always_ff @(posedge i_clock)
    if (i_reset) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // a bubble and a reset leave the ID/EX slot in the same all-zero state
  always_ff @(posedge i_clock)
    if (i_reset || !capture) begin
      o_valid <= 1'b0;
      o_data_ra <= '0;
      o_data_rb <= '0;
      o_imm <= '0;
      o_rs <= '0;
      o_rt <= '0;
      o_rd <= '0;
      o_opcode <= '0;
      o_funct <= '0;
    end else begin
      o_valid <= 1'b1;
      o_data_ra <= (opcode == OP_JAL) ? i_next_pc : o_cond_a;
      o_data_rb <= o_cond_b;
      o_imm <= imm;
      o_rs <= NB_REG'(rs_f);
      o_rt <= NB_REG'(rt_f);
      o_rd <= (opcode == OP_JAL) ? NB_REG'(5'd31) : NB_REG'(rd_f);
      o_opcode <= opcode;
      o_funct <= funct;
    end
`ifdef DECODE_BRANCH_CMP_EN
  assign o_branch_taken = i_valid && !o_stall &&
                          ((opcode == OP_BEQ && o_cond_a == o_cond_b) || (opcode == OP_BNE && o_cond_a != o_cond_b));
  assign o_branch_target = i_next_pc + (imm_sext << 2);
`else
  assign o_branch_taken = 1'b0;
  assign o_branch_target = '0;
`endif
endmodule
